// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins plus decoded key event bundle
interface keypad_scanner_if;
    logic       enable;
    logic [3:0] keypadCol;
    logic [3:0] keypadRow;
    logic       key_valid;
    logic [1:0] key_row;
    logic [1:0] key_col;
    logic       key_held;
    modport master (output enable, keypadCol, input keypadRow, key_valid, key_row, key_col, key_held);
    modport slave  (input enable, keypadCol, output keypadRow, key_valid, key_row, key_col, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad row scanner with column sync, debounce and one-shot press events
module keypad_scanner #(
    parameter int SCAN_DIV       = 250000,
    parameter int DEBOUNCE_SCANS = 3
) (
    input logic             clk,
    input logic             rst,
    keypad_scanner_if.slave kp
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);
    localparam logic [1:0] IDLE = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2;

    logic [CW-1:0] cnt;
    logic [1:0]    r, r_nxt, state, hit_col, krow, kcol;
    logic [3:0]    sync1, sync_col, row_q, scan_code, res_code, cand, stab, rel;
    logic          scan_vld, tick, scan_end, hit, res_vld, accept, valid_q;

    // row-step strobe, first pressed column of the sampled row, full-scan result and accept decision
    always_comb begin
        tick = kp.enable && cnt == DIV_LAST;
        scan_end = tick && r == 2'd3;
        r_nxt = tick ? r + 2'd1 : r;
        hit = ~&sync_col;
        hit_col = !sync_col[0] ? 2'd0 : !sync_col[1] ? 2'd1 : !sync_col[2] ? 2'd2 : 2'd3;
        res_vld = scan_vld || hit;
        res_code = scan_vld ? scan_code : {r, hit_col};
        accept = scan_end && res_vld &&
                 ((state == IDLE && DB == 4'd1) ||
                  (state == DEBOUNCE && res_code == cand && stab + 4'd1 == DB));
    end

    // two-flop synchroniser for the asynchronous column returns
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sync1 <= 4'hF;
            sync_col <= 4'hF;
        end else begin
            sync1 <= kp.keypadCol;
            sync_col <= sync1;
        end

    // row divider and registered active-low row drive, parked while disabled
    always_ff @(posedge clk or negedge rst)
        if (!rst || !kp.enable) begin
            cnt <= '0;
            r <= 2'd0;
            row_q <= 4'hF;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            r <= r_nxt;
            row_q <= ~(4'b0001 << r_nxt);
        end

    // first pressed key of the current scan in row-major order, cleared at scan end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            scan_vld <= 1'b0;
            scan_code <= 4'd0;
        end else if (!kp.enable || scan_end) begin
            scan_vld <= 1'b0;
            scan_code <= 4'd0;
        end else if (tick && hit && !scan_vld) begin
            scan_vld <= 1'b1;
            scan_code <= {r, hit_col};
        end

    // debounce / hold state machine, stepped once per completed scan
    always_ff @(posedge clk or negedge rst)
        if (!rst || !kp.enable) begin
            state <= IDLE;
            cand <= 4'd0;
            stab <= 4'd0;
            rel <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= accept;
            if (scan_end)
                case (state)
                    IDLE:
                        if (res_vld) begin
                            cand <= res_code;
                            stab <= accept ? 4'd0 : 4'd1;
                            state <= accept ? HELD : DEBOUNCE;
                        end
                    DEBOUNCE:
                        if (!res_vld) begin
                            state <= IDLE;
                            stab <= 4'd0;
                        end else if (accept) begin
                            state <= HELD;
                            stab <= 4'd0;
                            rel <= 4'd0;
                        end else if (res_code == cand) begin
                            stab <= stab + 4'd1;
                        end else begin
                            cand <= res_code;
                            stab <= 4'd1;
                        end
                    HELD:
                        if (res_vld) begin
                            rel <= 4'd0;
                        end else if (rel + 4'd1 == DB) begin
                            state <= IDLE;
                            rel <= 4'd0;
                        end else begin
                            rel <= rel + 4'd1;
                        end
                    default: state <= IDLE;
                endcase
        end

    // last accepted code survives enable drops and is cleared only by reset
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            krow <= 2'd0;
            kcol <= 2'd0;
        end else if (accept) begin
            krow <= res_code[3:2];
            kcol <= res_code[1:0];
        end

    assign kp.keypadRow = row_q;
    assign kp.key_valid = valid_q;
    assign kp.key_row = krow;
    assign kp.key_col = kcol;
    assign kp.key_held = state == HELD;
endmodule
